// File: rtl/cmd_frame_master.sv
// cmd_frame_master: host-side initiator that serializes one command into the
// byte-serial register-file/ALU frame (AA write, BB read, CC ALU+operands,
// DD ALU func only) and then gathers the LSB-first response into one word.
module cmd_frame_master #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [1:0]              req_cmd_i,
  input  logic [ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [DATA_WIDTH-1:0]   req_data_i,
  input  logic [DATA_WIDTH-1:0]   req_op_a_i,
  input  logic [DATA_WIDTH-1:0]   req_op_b_i,
  input  logic [3:0]              req_func_i,
  output logic [DATA_WIDTH-1:0]   tx_data_o,
  output logic                    tx_valid_o,
  input  logic                    tx_busy_i,
  input  logic [DATA_WIDTH-1:0]   rx_data_i,
  input  logic                    rx_valid_i,
  output logic [2*DATA_WIDTH-1:0] rsp_data_o,
  output logic                    rsp_valid_o,
  output logic                    rsp_timeout_o,
  output logic                    done_o
);

  localparam logic [1:0] CMD_WR  = 2'b00;
  localparam logic [1:0] CMD_RD  = 2'b01;
  localparam logic [1:0] CMD_ALU = 2'b10;
  localparam logic [1:0] CMD_FN  = 2'b11;

  // Counter only needs to reach TIMEOUT_CYCLES-1.
  localparam int            CW      = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_TX_BYTE, S_RSP_LO, S_RSP_HI} state_t;

  state_t                  state_q;
  logic [1:0]              cmd_q;
  logic [1:0]              idx_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic [DATA_WIDTH-1:0]   op_a_q;
  logic [DATA_WIDTH-1:0]   op_b_q;
  logic [3:0]              func_q;
  logic [DATA_WIDTH-1:0]   low_q;
  logic [CW-1:0]           tmo_q;
  logic [DATA_WIDTH-1:0]   tx_data_q;
  logic                    tx_valid_q;
  logic [2*DATA_WIDTH-1:0] rsp_data_q;
  logic                    rsp_valid_q;
  logic                    rsp_timeout_q;
  logic                    done_q;

  logic [1:0]              idx_d;
  logic [DATA_WIDTH-1:0]   byte_d;
  logic [1:0]              last_idx;
  logic [DATA_WIDTH-1:0]   addr_byte;
  logic [DATA_WIDTH-1:0]   func_byte;

  // Header byte for a command code, chosen directly from the request at acceptance.
  function automatic logic [DATA_WIDTH-1:0] hdr_byte(input logic [1:0] cmd);
    case (cmd)
      CMD_WR:  hdr_byte = DATA_WIDTH'(8'hAA);
      CMD_RD:  hdr_byte = DATA_WIDTH'(8'hBB);
      CMD_ALU: hdr_byte = DATA_WIDTH'(8'hCC);
      default: hdr_byte = DATA_WIDTH'(8'hDD);
    endcase
  endfunction

  assign addr_byte = DATA_WIDTH'(addr_q);
  assign func_byte = DATA_WIDTH'(func_q);

  // Frame length and the byte that follows the one currently on the wire.
  always_comb begin
    idx_d    = idx_q + 2'd1;
    byte_d   = '0;
    last_idx = 2'd1;
    case (cmd_q)
      CMD_WR: begin
        last_idx = 2'd2;
        byte_d   = (idx_d == 2'd1) ? addr_byte : data_q;
      end
      CMD_RD: begin
        byte_d = addr_byte;
      end
      CMD_ALU: begin
        last_idx = 2'd3;
        case (idx_d)
          2'd1:    byte_d = op_a_q;
          2'd2:    byte_d = op_b_q;
          default: byte_d = func_byte;
        endcase
      end
      default: begin
        byte_d = func_byte;
      end
    endcase
  end

  // Main controller: capture, transmit, collect response, time out.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= S_IDLE;
      cmd_q         <= '0;
      idx_q         <= '0;
      addr_q        <= '0;
      data_q        <= '0;
      op_a_q        <= '0;
      op_b_q        <= '0;
      func_q        <= '0;
      low_q         <= '0;
      tmo_q         <= '0;
      tx_data_q     <= '0;
      tx_valid_q    <= 1'b0;
      rsp_data_q    <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      rsp_valid_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
      done_q        <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_valid_i) begin
            cmd_q      <= req_cmd_i;
            addr_q     <= req_addr_i;
            data_q     <= req_data_i;
            op_a_q     <= req_op_a_i;
            op_b_q     <= req_op_b_i;
            func_q     <= req_func_i;
            idx_q      <= 2'd0;
            tx_data_q  <= hdr_byte(req_cmd_i);
            tx_valid_q <= 1'b1;
            state_q    <= S_TX_BYTE;
          end
        end
        S_TX_BYTE: begin
          if (!tx_busy_i) begin
            if (idx_q == last_idx) begin
              tx_valid_q <= 1'b0;
              tmo_q      <= '0;
              if (cmd_q == CMD_WR) begin
                done_q  <= 1'b1;
                state_q <= S_IDLE;
              end else begin
                state_q <= S_RSP_LO;
              end
            end else begin
              idx_q     <= idx_d;
              tx_data_q <= byte_d;
            end
          end
        end
        S_RSP_LO, S_RSP_HI: begin
          if (rx_valid_i) begin
            tmo_q <= '0;
            if (state_q == S_RSP_HI) begin
              rsp_data_q  <= {rx_data_i, low_q};
              rsp_valid_q <= 1'b1;
              done_q      <= 1'b1;
              state_q     <= S_IDLE;
            end else if (cmd_q == CMD_RD) begin
              rsp_data_q  <= {{DATA_WIDTH{1'b0}}, rx_data_i};
              rsp_valid_q <= 1'b1;
              done_q      <= 1'b1;
              state_q     <= S_IDLE;
            end else begin
              low_q   <= rx_data_i;
              state_q <= S_RSP_HI;
            end
          end else if (tmo_q == TO_LAST) begin
            tmo_q         <= '0;
            rsp_timeout_q <= 1'b1;
            done_q        <= 1'b1;
            state_q       <= S_IDLE;
          end else begin
            tmo_q <= tmo_q + CW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready_o   = (state_q == S_IDLE);
  assign tx_data_o     = tx_data_q;
  assign tx_valid_o    = tx_valid_q;
  assign rsp_data_o    = rsp_data_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_timeout_o = rsp_timeout_q;
  assign done_o        = done_q;

endmodule

// File: tb/tb_cmd_frame_master.sv
// Directed bench for cmd_frame_master with a 20-cycle response timeout.
module tb_cmd_frame_master;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_cmd = '0;
  logic [3:0]  req_addr = '0;
  logic [7:0]  req_data = '0;
  logic [7:0]  req_op_a = '0;
  logic [7:0]  req_op_b = '0;
  logic [3:0]  req_func = '0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_busy = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic [15:0] rsp_data;
  logic        rsp_valid;
  logic        rsp_timeout;
  logic        done;

  int vec_cnt = 0;
  int err_cnt = 0;

  cmd_frame_master #(
    .DATA_WIDTH    (8),
    .ADDR_WIDTH    (4),
    .TIMEOUT_CYCLES(20)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_cmd_i    (req_cmd),
    .req_addr_i   (req_addr),
    .req_data_i   (req_data),
    .req_op_a_i   (req_op_a),
    .req_op_b_i   (req_op_b),
    .req_func_i   (req_func),
    .tx_data_o    (tx_data),
    .tx_valid_o   (tx_valid),
    .tx_busy_i    (tx_busy),
    .rx_data_i    (rx_data),
    .rx_valid_i   (rx_valid),
    .rsp_data_o   (rsp_data),
    .rsp_valid_o  (rsp_valid),
    .rsp_timeout_o(rsp_timeout),
    .done_o       (done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one cycle, then scramble the fields to prove capture.
  task automatic accept(input logic [1:0] cmd, input logic [3:0] addr, input logic [7:0] data,
                        input logic [7:0] a, input logic [7:0] b, input logic [3:0] func);
    req_cmd   = cmd;
    req_addr  = addr;
    req_data  = data;
    req_op_a  = a;
    req_op_b  = b;
    req_func  = func;
    req_valid = 1'b1;
    check_val("acc_ready", req_ready, 1);
    tick();
    req_valid = 1'b0;
    req_cmd   = 2'($urandom);
    req_addr  = 4'($urandom);
    req_data  = 8'($urandom);
    req_op_a  = 8'($urandom);
    req_op_b  = 8'($urandom);
    req_func  = 4'($urandom);
  endtask

  // Expect n bytes (first in frm[31:24]), each preceded by 'stall' busy cycles.
  task automatic send_frame(input logic [31:0] frm, input int n, input int stall, input bit rx_glitch);
    logic [7:0] exp_b;
    for (int i = 0; i < n; i++) begin
      exp_b = frm[31-8*i -: 8];
      for (int s = 0; s < stall; s++) begin
        tx_busy = 1'b1;
        check_val("stall_valid", tx_valid, 1);
        check_val("stall_data", tx_data, exp_b);
        tick();
      end
      tx_busy = 1'b0;
      if (rx_glitch && i == n - 1) begin
        rx_valid = 1'b1;
        rx_data  = 8'hEE;
      end
      check_val("tx_valid", tx_valid, 1);
      check_val("tx_data", tx_data, exp_b);
      check_val("tx_ready", req_ready, 0);
      check_val("tx_done", done, 0);
      tick();
      rx_valid = 1'b0;
    end
    check_val("tx_vfall", tx_valid, 0);
  endtask

  task automatic rx_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  // Count cycles until the timeout pulse, bounded.
  task automatic wait_timeout(input string tag);
    int n;
    bit seen_v;
    n = 0;
    seen_v = 1'b0;
    while (!rsp_timeout && n < 60) begin
      if (rsp_valid) seen_v = 1'b1;
      tick();
      n++;
    end
    check_val({tag, "_lat"}, n, 20);
    check_val({tag, "_done"}, done, 1);
    check_val({tag, "_valid"}, rsp_valid, 0);
    check_val({tag, "_ready"}, req_ready, 1);
    check_val({tag, "_novalid"}, seen_v, 0);
    check_val({tag, "_keep"}, rsp_data, 16'h0408);
    tick();
    check_val({tag, "_pulse1"}, rsp_timeout, 0);
    check_val({tag, "_done1"}, done, 0);
  endtask

  initial begin
    #2 rst = 1'b1;
    tick();
    tick();
    check_val("rst_txv", tx_valid, 0);
    check_val("rst_txd", tx_data, 0);
    check_val("rst_rsp", rsp_data, 0);
    check_val("rst_rspv", rsp_valid, 0);
    check_val("rst_to", rsp_timeout, 0);
    check_val("rst_done", done, 0);
    check_val("rst_ready", req_ready, 1);
    rst = 1'b0;
    tick();

    // Write: AA 05 3C, done one cycle after the last byte.
    accept(2'b00, 4'h5, 8'h3C, 8'h00, 8'h00, 4'h0);
    send_frame(32'hAA053C00, 3, 0, 1'b0);
    check_val("wr_done", done, 1);
    check_val("wr_ready", req_ready, 1);
    check_val("wr_rspv", rsp_valid, 0);
    tick();
    check_val("wr_done1", done, 0);
    $display("txn write addr=5 data=3c");

    // Read: BB 0A, RX seen during the last TX byte ignored, 0x77 after 10 cycles.
    accept(2'b01, 4'hA, 8'h00, 8'h00, 8'h00, 4'h0);
    send_frame(32'hBB0A0000, 2, 0, 1'b1);
    for (int i = 0; i < 9; i++) begin
      check_val("rd_wait_v", rsp_valid, 0);
      check_val("rd_wait_d", done, 0);
      tick();
    end
    rx_byte(8'h77);
    check_val("rd_valid", rsp_valid, 1);
    check_val("rd_done", done, 1);
    check_val("rd_data", rsp_data, 16'h0077);
    check_val("rd_to", rsp_timeout, 0);
    check_val("rd_ready", req_ready, 1);
    tick();
    check_val("rd_valid1", rsp_valid, 0);
    check_val("rd_done1", done, 0);
    $display("txn read addr=a rsp=%04h", rsp_data);

    // ALU with operands and 3-cycle stalls before each byte.
    accept(2'b10, 4'h0, 8'h00, 8'h12, 8'h34, 4'h0);
    send_frame(32'hCC123400, 4, 3, 1'b0);
    tick();
    tick();
    rx_byte(8'h46);
    check_val("alu_lo_v", rsp_valid, 0);
    check_val("alu_lo_d", done, 0);
    tick();
    rx_byte(8'h00);
    check_val("alu_valid", rsp_valid, 1);
    check_val("alu_done", done, 1);
    check_val("alu_data", rsp_data, 16'h0046);
    tick();
    $display("txn alu a=12 b=34 f=0 rsp=%04h", rsp_data);

    // ALU function only, then a stray RX in IDLE.
    accept(2'b11, 4'h0, 8'h00, 8'h00, 8'h00, 4'h2);
    send_frame(32'hDD020000, 2, 0, 1'b0);
    rx_byte(8'h08);
    rx_byte(8'h04);
    check_val("fn_valid", rsp_valid, 1);
    check_val("fn_data", rsp_data, 16'h0408);
    tick();
    rx_byte(8'h99);
    check_val("stray_data", rsp_data, 16'h0408);
    check_val("stray_v", rsp_valid, 0);
    check_val("stray_d", done, 0);
    $display("txn alufn f=2 rsp=%04h", rsp_data);

    // Read with no response.
    accept(2'b01, 4'h3, 8'h00, 8'h00, 8'h00, 4'h0);
    send_frame(32'hBB030000, 2, 0, 1'b0);
    wait_timeout("rdto");
    $display("txn read addr=3 timeout");

    // ALU with a single response byte, then silence.
    accept(2'b10, 4'h0, 8'h00, 8'h01, 8'h02, 4'h3);
    send_frame(32'hCC010203, 4, 0, 1'b0);
    rx_byte(8'h55);
    wait_timeout("aluto");
    $display("txn alu a=01 b=02 f=3 timeout");

    // Reset right after the CC header transfers.
    accept(2'b10, 4'h0, 8'h00, 8'hAB, 8'hCD, 4'h1);
    check_val("rst_hdr", tx_data, 8'hCC);
    tick();
    check_val("rst_next", tx_data, 8'hAB);
    rst = 1'b1;
    #1;
    check_val("rst_async_v", tx_valid, 0);
    check_val("rst_async_r", req_ready, 1);
    check_val("rst_async_d", done, 0);
    tick();
    rst = 1'b0;
    check_val("rst_rel_d", done, 0);
    tick();
    check_val("rst_rel_d1", done, 0);
    check_val("rst_rel_v", rsp_valid, 0);
    check_val("rst_rel_r", req_ready, 1);
    check_val("rst_rel_rsp", rsp_data, 0);
    accept(2'b01, 4'h6, 8'h00, 8'h00, 8'h00, 4'h0);
    send_frame(32'hBB060000, 2, 0, 1'b0);
    rx_byte(8'h11);
    check_val("post_rst_data", rsp_data, 16'h0011);
    check_val("post_rst_valid", rsp_valid, 1);
    $display("txn reset then read addr=6 rsp=%04h", rsp_data);

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
